// File: rtl/if_id_stage_pkg.sv
// Shared constants for the fetch/decode boundary: FSM state encoding,
// bubble encoding and the "immediate follows" flag position.
package if_id_stage_pkg;

    typedef enum logic {
        S_OP  = 1'b0,
        S_IMM = 1'b1
    } state_e;

    localparam int          IMM_FLAG_BIT_C = 11;
    localparam logic [15:0] NOP_WORD_C     = 16'h0000;

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: merges opcode + immediate word pairs into one
// decode packet, with stall (hold) and flush (bubble) from control.
module if_id_stage
    import if_id_stage_pkg::*;
#(
    parameter int          IMM_FLAG_BIT = IMM_FLAG_BIT_C,
    parameter logic [15:0] NOP_WORD     = NOP_WORD_C,
    parameter int          PC_W         = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [15:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    input  logic            stall,
    input  logic            flush,
    output logic            id_valid,
    output logic [15:0]     id_instr,
    output logic [15:0]     id_imm,
    output logic [PC_W-1:0] id_pc,
    output logic            imm_wait
);

    state_e          state_q, state_d;
    logic [15:0]     held_op_q, held_op_d;
    logic            valid_q, valid_d;
    logic [15:0]     instr_q, instr_d;
    logic [15:0]     imm_q, imm_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            wait_q, wait_d;

    always_comb begin
        state_d   = state_q;
        held_op_d = held_op_q;
        valid_d   = valid_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        pc_d      = pc_q;

        if (flush) begin
            // id_pc deliberately survives a flush
            state_d   = S_OP;
            held_op_d = '0;
            valid_d   = 1'b0;
            instr_d   = NOP_WORD;
            imm_d     = '0;
        end else if (!stall) begin
            valid_d = 1'b0;
            instr_d = NOP_WORD;
            imm_d   = '0;
            if (if_valid) begin
                if (state_q == S_IMM) begin
                    valid_d   = 1'b1;
                    instr_d   = held_op_q;
                    imm_d     = if_instr;
                    pc_d      = if_pc;
                    state_d   = S_OP;
                end else if (if_instr[IMM_FLAG_BIT]) begin
                    held_op_d = if_instr;
                    state_d   = S_IMM;
                end else begin
                    valid_d   = 1'b1;
                    instr_d   = if_instr;
                    pc_d      = if_pc;
                end
            end
        end
        wait_d = (state_d == S_IMM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_OP;
            held_op_q <= '0;
            valid_q   <= 1'b0;
            instr_q   <= NOP_WORD;
            imm_q     <= '0;
            pc_q      <= '0;
            wait_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            held_op_q <= held_op_d;
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            wait_q    <= wait_d;
        end
    end

    assign id_valid = valid_q;
    assign id_instr = instr_q;
    assign id_imm   = imm_q;
    assign id_pc    = pc_q;
    assign imm_wait = wait_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed + random bench for if_id_stage against a packet-level reference model.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [31:0] if_pc;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_imm;
    logic [31:0] id_pc;
    logic        imm_wait;

    int compared   = 0;
    int mismatched = 0;

    // reference model: expected packet plus the pending opcode, if any
    bit          m_pending;
    logic [15:0] m_op;
    logic        e_valid;
    logic [15:0] e_instr, e_imm;
    logic [31:0] e_pc;

    if_id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_instr(id_instr), .id_imm(id_imm), .id_pc(id_pc), .imm_wait(imm_wait)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_op = 16'h0;
        e_valid = 0; e_instr = 16'h0; e_imm = 16'h0; e_pc = 32'h0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] w, input logic [31:0] pc,
                              input logic st, input logic fl);
        if (fl) begin
            m_pending = 0; m_op = 16'h0;
            e_valid = 0; e_instr = 16'h0; e_imm = 16'h0;
        end else if (!st) begin
            e_valid = 0; e_instr = 16'h0; e_imm = 16'h0;
            if (v && m_pending) begin
                e_valid = 1; e_instr = m_op; e_imm = w; e_pc = pc;
                m_pending = 0;
            end else if (v && w[11]) begin
                m_pending = 1; m_op = w;
            end else if (v) begin
                e_valid = 1; e_instr = w; e_pc = pc;
            end
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, e_valid});
        chk({tag, ".instr"}, {16'b0, id_instr}, {16'b0, e_instr});
        chk({tag, ".imm"},   {16'b0, id_imm},   {16'b0, e_imm});
        chk({tag, ".pc"},    id_pc,             e_pc);
        chk({tag, ".wait"},  {31'b0, imm_wait}, {31'b0, m_pending});
    endtask

    task automatic step(input string tag, input logic v, input logic [15:0] w,
                        input logic [31:0] pc, input logic st, input logic fl);
        if_valid = v; if_instr = w; if_pc = pc; stall = st; flush = fl;
        @(posedge clk);
        #1;
        model_step(v, w, pc, st, fl);
        chk_all(tag);
    endtask

    initial begin
        rst = 1'b1; if_valid = 0; if_instr = 16'h0; if_pc = 32'h0; stall = 0; flush = 0;
        model_reset();
        @(posedge clk); #1;
        chk_all("reset");
        rst = 1'b0;

        // 2: back-to-back one-word instructions
        step("t2a", 1, 16'h0123, 32'h21, 0, 0);
        chk("t2a.lit", {16'b0, id_instr}, 32'h0123);
        step("t2b", 1, 16'h0456, 32'h22, 0, 0);
        chk("t2b.lit_pc", id_pc, 32'h22);

        // 3: two-word instruction
        step("t3a", 1, 16'h0805, 32'h30, 0, 0);
        chk("t3a.wait", {31'b0, imm_wait}, 32'h1);
        step("t3b", 1, 16'hBEEF, 32'h31, 0, 0);
        chk("t3b.lit_imm", {16'b0, id_imm}, 32'hBEEF);
        chk("t3b.wait", {31'b0, imm_wait}, 32'h0);

        // 1: asynchronous reset mid-cycle, taken while an opcode is pending
        step("t1a", 1, 16'h0805, 32'h40, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_all("t1.async");
        chk("t1.lit_instr", {16'b0, id_instr}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        step("t1b", 1, 16'h0077, 32'h41, 0, 0);   // opcode lost: plain one-word instr

        // 4: stall while waiting for the immediate
        step("t4a", 1, 16'h0805, 32'h50, 0, 0);
        for (int i = 0; i < 3; i++) step("t4stall", 1, 16'h1234, 32'h51, 1, 0);
        step("t4rel", 1, 16'h1234, 32'h51, 0, 0);
        chk("t4.lit_imm", {16'b0, id_imm}, 32'h1234);
        step("t4after", 0, 16'h0, 32'h0, 0, 0);

        // 5: flush and stall together in S_IMM
        step("t5a", 1, 16'h0805, 32'h60, 0, 0);
        step("t5fl", 1, 16'h9999, 32'h61, 1, 1);
        chk("t5.lit_wait", {31'b0, imm_wait}, 32'h0);
        step("t5b", 1, 16'h0042, 32'h62, 0, 0);
        chk("t5.lit_instr", {16'b0, id_instr}, 32'h0042);

        // 6: fetch gaps between opcode and immediate
        step("t6a", 1, 16'h0805, 32'h70, 0, 0);
        step("t6gap", 0, 16'hAAAA, 32'h0, 0, 0);
        step("t6gap", 0, 16'h5555, 32'h0, 0, 0);
        step("t6b", 1, 16'h00FF, 32'h73, 0, 0);
        chk("t6.lit_imm", {16'b0, id_imm}, 32'h00FF);
        step("t6c", 0, 16'h0, 32'h0, 0, 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic        v, st, fl;
            logic [15:0] w;
            v  = ($urandom_range(0, 3) != 0);
            st = ($urandom_range(0, 6) == 0);
            fl = ($urandom_range(0, 11) == 0);
            w  = 16'($urandom);
            step("rand", v, w, $urandom, st, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
